// File: rtl/float_norm_round_if.sv
// Handshake and data bundle between the adder's result-select stage and the
// normalise/round/pack back end.
interface float_norm_round_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  logic                   start;
  logic                   sign_in;
  logic [EXP_W-1:0]       exp_in;
  logic [MAN_W+4:0]       frac_in;
  logic                   busy;
  logic                   done;
  logic [EXP_W+MAN_W:0]   result;
  logic                   overflow;
  logic                   underflow;

  modport slave (
    input  start, sign_in, exp_in, frac_in,
    output busy, done, result, overflow, underflow
  );

  modport master (
    output start, sign_in, exp_in, frac_in,
    input  busy, done, result, overflow, underflow
  );
endinterface

// File: rtl/float_norm_round.sv
// Normalise, round-to-nearest-even and pack stage of the float adder.
// Left normalisation walks one bit per clock; result and flags register on leaving PACK.
module float_norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic               clk,
  input logic               res,
  float_norm_round_if.slave bus
);
  localparam int FW = MAN_W + 5;
  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_NORM, S_ROUND, S_PACK} state_t;

  state_t               state_q, state_d;
  logic                 sign_q, sign_d;
  logic [XW-1:0]        exp_q, exp_d;
  logic [FW-1:0]        frac_q, frac_d;
  logic                 zero_q, zero_d;
  logic                 flush_q, flush_d;
  logic [EXP_W+MAN_W:0] result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 done_q, done_d;
  logic                 round_up;
  logic [XW-1:0]        exp_fin;
  logic [MAN_W-1:0]     man_fin;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      frac_q   <= '0;
      zero_q   <= 1'b0;
      flush_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      frac_q   <= frac_d;
      zero_q   <= zero_d;
      flush_q  <= flush_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    frac_d   = frac_q;
    zero_d   = zero_q;
    flush_d  = flush_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    done_d   = 1'b0;
    round_up = frac_q[2] & (frac_q[1] | frac_q[0] | frac_q[3]);
    exp_fin  = exp_q + XW'(frac_q[FW-1]);
    man_fin  = frac_q[FW-1] ? frac_q[FW-2:4] : frac_q[FW-3:3];

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sign_d  = bus.sign_in;
          exp_d   = XW'(bus.exp_in);
          frac_d  = bus.frac_in;
          zero_d  = 1'b0;
          flush_d = 1'b0;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        // Right shift folds the two dropped bits into sticky.
        if (frac_q[FW-1]) begin
          frac_d = {1'b0, frac_q[FW-1:2], frac_q[1] | frac_q[0]};
          exp_d  = exp_q + XW'(1);
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (frac_q == '0) begin
          zero_d  = 1'b1;
          state_d = S_PACK;
        end else if (frac_q[FW-2]) begin
          state_d = S_ROUND;
        end else if (exp_q == XW'(1)) begin
          flush_d = 1'b1;
          state_d = S_PACK;
        end else begin
          frac_d = {frac_q[FW-2:0], 1'b0};
          exp_d  = exp_q - XW'(1);
        end
      end
      S_ROUND: begin
        frac_d  = frac_q + (FW'(round_up) << 3);
        state_d = S_PACK;
      end
      S_PACK: begin
        done_d  = 1'b1;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        state_d = S_IDLE;
        if (zero_q || flush_q) begin
          result_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
          unf_d    = flush_q;
        end else if (exp_fin >= EXP_MAX) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_fin[EXP_W-1:0], man_fin};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule
